n2t_fetch: RTL
==============

# n2t_fetch

Instruction fetch stage sitting directly downstream of the `n2t_PC` program counter. It issues the current fetch address to the instruction ROM over a req/ack handshake, captures the returned 16-bit word into an instruction register, and presents it to decode with a valid/ready handshake. It also drives the PC's `inc`/`load`/`in` controls so the PC tracks the fetch address and is redirected on jumps. A flush discards any in-flight or held instruction.

## Interface
- `ADDR_W`, default 15: ROM address width; `mem_addr` is the low `ADDR_W` bits of `fetch_addr`.
- `clk`  in  1  system clock, all state on rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low; synchronously released by the top level.
- `pc_inc`  out  1  one-cycle pulse to PC `inc`.
- `pc_load`  out  1  one-cycle pulse to PC `load`.
- `pc_din`  out  16  value for PC `in`; valid when `pc_load`=1.
- `mem_req`  out  1  ROM read request.
- `mem_addr`  out  ADDR_W  ROM address; stable while `mem_req`=1.
- `mem_ack`  in  1  ROM read done; `mem_rdata` valid this cycle.
- `mem_rdata`  in  16  ROM read data.
- `instr`  out  16  fetched instruction.
- `instr_addr`  out  16  address `instr` was read from.
- `instr_valid`  out  1  `instr`/`instr_addr` valid.
- `instr_ready`  in  1  decode accepts; transfer when valid && ready.
- `jump`  in  1  redirect request, sampled every edge.
- `jump_target`  in  16  new fetch address when `jump`=1.

## Operation
- Internal 16-bit `fetch_addr` mirrors the PC: PC holds the address of the next word to fetch, lagging `fetch_addr` by one cycle.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: entered at reset; next edge -> REQ.
- REQ: `mem_req`=1, `mem_addr`=`fetch_addr[ADDR_W-1:0]`; -> WAIT.
- WAIT: `mem_req` held 1 until `mem_ack`. On ack: `instr`<=`mem_rdata`, `instr_addr`<=`fetch_addr`, `instr_valid`<=1, `fetch_addr`<=`fetch_addr`+1 (16-bit wrap, 0xFFFF -> 0x0000), `pc_inc` pulsed; -> HOLD.
- HOLD: `instr_valid`=1 until valid && ready; on transfer `instr_valid`<=0 and -> REQ.
- Jump (any state): `fetch_addr`<=`jump_target`, `pc_load`=1 and `pc_din`=`jump_target` for one cycle, `instr_valid`<=0, `pc_inc` suppressed that cycle.
  - If a request is outstanding (REQ or WAIT without ack this cycle): -> DRAIN, keep `mem_req`=1 until `mem_ack`, discard data, no `pc_inc`; then -> REQ.
  - Otherwise -> REQ.
- Jump beats ack and transfer in the same cycle: ack data discarded, transferred instruction still counts as consumed by decode.
- `pc_inc` and `pc_load` are never 1 together.
- Mid-operation reset: all state abandoned immediately; ROM ignores `mem_req` drop.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `instr`=0, `instr_addr`=0, `instr_valid`=0, `pc_inc`=0, `pc_load`=0, `pc_din`=0, `fetch_addr`=0, state IDLE.
- All outputs registered.
- Zero-wait ROM (ack in the first `mem_req` cycle): `mem_req` rises edge E1, `instr_valid` rises E2, `pc_inc` high E2–E3.
- Without prefetch: with `instr_ready` tied 1, throughput is one instruction per 3 cycles.
- Jump: `pc_load` high for the cycle after the sampling edge; the first request to `jump_target` starts the following edge (no drain needed).

## Configuration
- `N2T_FETCH_PREFETCH_EN` defined: one-entry prefetch buffer.
  - On ack, the next request is issued immediately, even while `instr` is held.
  - The second word is parked in the buffer and moves to `instr` on transfer.
  - Requests stall only when both `instr` and the buffer are full.
  - A jump clears the buffer too.
  - With a zero-wait ROM and `instr_ready`=1, throughput is one instruction per 2 cycles.
- Not defined: no buffer; behaviour exactly as in Operation.

## Test plan
- Reset, zero-wait ROM holding words = address, `instr_ready`=1 -> `instr` 0x0000, 0x0001, 0x0002 with matching `instr_addr`; exactly one `pc_inc` per word.
- ROM acks 3 cycles late -> `mem_req`/`mem_addr` stable for all wait cycles; `instr_valid` rises the edge after ack.
- `instr_ready`=0 for 5 cycles while valid -> `instr` held unchanged, no new `mem_req` without the macro; one extra fetch then stall with it.
- `jump` with `jump_target`=0x0100 during WAIT -> `pc_load`=1 with `pc_din`=0x0100, `instr_valid` cleared, late ack data discarded, next `mem_addr`=0x0100.
- `jump` in the same cycle as `mem_ack` -> ack data dropped, no `pc_inc`, fetch resumes at the target.
- `fetch_addr`=0xFFFF fetched -> `instr_addr`=0xFFFF, next `mem_addr`=0; `reset_n` low during WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/n2t_fetch.sv
// n2t_fetch: instruction fetch stage driving n2t_PC and the instruction ROM.
// Optional one-entry prefetch buffer enabled by `define N2T_FETCH_PREFETCH_EN.
module n2t_fetch #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [15:0]       pc_din,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       instr,
    output logic [15:0]       instr_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump,
    input  logic [15:0]       jump_target
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    logic [15:0] fetch_addr;
    logic        xfer;
    logic        take;
    logic        park;

    assign xfer = instr_valid & instr_ready;
    assign take = (state == WAIT) & mem_ack;

`ifdef N2T_FETCH_PREFETCH_EN
    logic [15:0] buf_data;
    logic [15:0] buf_addr;
    logic        buf_valid;
    logic [1:0]  occ_next;

    // Park in HOLD only when instr and the buffer will both be occupied.
    always_comb begin
        occ_next = {1'b0, instr_valid} + {1'b0, buf_valid}
                 + {1'b0, take} - {1'b0, xfer};
        park     = (occ_next == 2'd2);
    end
`else
    assign park = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            fetch_addr  <= '0;
            pc_inc      <= 1'b0;
            pc_load     <= 1'b0;
            pc_din      <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
`ifdef N2T_FETCH_PREFETCH_EN
            buf_data    <= '0;
            buf_addr    <= '0;
            buf_valid   <= 1'b0;
`endif
        end else begin
            pc_inc  <= 1'b0;
            pc_load <= 1'b0;
            if (jump) begin
                fetch_addr  <= jump_target;
                pc_load     <= 1'b1;
                pc_din      <= jump_target;
                instr_valid <= 1'b0;
`ifdef N2T_FETCH_PREFETCH_EN
                buf_valid   <= 1'b0;
`endif
                // An unanswered ROM read must complete before re-issuing.
                if ((state == WAIT || state == DRAIN) && !mem_ack) begin
                    state <= DRAIN;
                end else begin
                    state   <= REQ;
                    mem_req <= 1'b0;
                end
            end else begin
`ifdef N2T_FETCH_PREFETCH_EN
                if (xfer) begin
                    if (buf_valid) begin
                        instr      <= buf_data;
                        instr_addr <= buf_addr;
                        if (take) begin
                            buf_data <= mem_rdata;
                            buf_addr <= fetch_addr;
                        end else begin
                            buf_valid <= 1'b0;
                        end
                    end else if (take) begin
                        instr      <= mem_rdata;
                        instr_addr <= fetch_addr;
                    end else begin
                        instr_valid <= 1'b0;
                    end
                end else if (take) begin
                    if (instr_valid) begin
                        buf_data  <= mem_rdata;
                        buf_addr  <= fetch_addr;
                        buf_valid <= 1'b1;
                    end else begin
                        instr       <= mem_rdata;
                        instr_addr  <= fetch_addr;
                        instr_valid <= 1'b1;
                    end
                end
`else
                if (take) begin
                    instr       <= mem_rdata;
                    instr_addr  <= fetch_addr;
                    instr_valid <= 1'b1;
                end else if (xfer) begin
                    instr_valid <= 1'b0;
                end
`endif
                if (take) begin
                    fetch_addr <= fetch_addr + 16'd1;
                    pc_inc     <= 1'b1;
                end
                unique case (state)
                    IDLE: state <= REQ;
                    REQ: begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_addr[ADDR_W-1:0];
                        state    <= WAIT;
                    end
                    WAIT: begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            state   <= park ? HOLD : REQ;
                        end
                    end
                    HOLD: begin
                        if (xfer) state <= REQ;
                    end
                    DRAIN: begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            state   <= REQ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
